rr_arbiter_param: RTL and testbench
===================================

// Module: rr_arbiter_param
// PURPOSE
//  N-way round-robin arbiter with registered one-hot grant and grant-hold semantics.
//  Optional hold-time limit that preempts a long-running owner.
//  Sits in front of the shared accumulator/adder path.
//  Successor to the 4-way arbiter: parametrised width, explicit reset, index output, fairness cap.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  MAX_HOLD  0   max consecutive grant cycles per owner when others wait; 0 = unlimited
//  IDX_W     2   grant_idx width; must equal clog2(N)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req          in   N      request vector; a requester holds req high for the whole transaction
//  grant        out  N      registered one-hot grant; all-zero = idle
//  grant_idx    out  IDX_W  binary index of the owner; 0 when idle
//  grant_valid  out  1      |grant, registered
// BEHAVIOUR
//  Reset (async assert; first arbitration at the first edge after deassert)
//   - grant=0, grant_idx=0, grant_valid=0.
//   - Priority pointer ptr=0, so req[0] ranks highest first. hold_cnt=0.
//  States: IDLE (grant==0), OWNED (grant one-hot).
//  Latency: req sampled at posedge k is reflected in grant after edge k. No combinational req->grant path.
//  Pick: first set bit of req scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (masked/unmasked pair).
//  IDLE:
//   - req!=0 -> OWNED with the pick; ptr<=(pick+1)%N; hold_cnt<=0.
//   - req==0 -> stay IDLE.
//  OWNED with owner o:
//   - req[o]==0 (release):
//     - Same edge, grant the pick from the remaining requests (zero-bubble handoff), ptr/hold_cnt as above.
//     - If no other request, -> IDLE.
//   - req[o]==1 and MAX_HOLD>0 and hold_cnt==MAX_HOLD-1 and (req & ~grant)!=0 (preempt):
//     - Grant the pick among req & ~grant; o must re-win later.
//   - Otherwise hold grant.
//     - hold_cnt increments, saturating at MAX_HOLD-1.
//     - When alone, the owner holds indefinitely.
//  Invariants:
//   - grant is zero or one-hot.
//   - grant never changes except at release, preemption or reset.
//   - A newly issued grant always targets a bit set in req at that edge.
//  Starvation bound with MAX_HOLD=H>0: any held request is granted within (N-1)*H edges.
//  Request glitch: req[o] low for one sampled edge counts as release; re-raising it competes normally.
//  Reset mid-grant: grant drops immediately (async); ptr returns to 0.
// STRUCTURE
//  Shared include arb_defs.vh: clog2 function, ARB_IDLE/ARB_OWNED state encodings.
//  Sub-module fixed_priority_pick #(N): lowest-index one-hot pick, combinational.
//   - Instantiated twice: masked by thermometer(ptr), and unmasked.
//   - The masked result wins if non-zero.
//  Top: state/grant/ptr/hold_cnt registers, onehot->index encoder, hold counter.
// TESTING (N=4; MAX_HOLD=0 unless stated)
//  Reset, req=0101 held -> grant=0001 after edge 1, idx=0. Drop req[0] -> grant=0100 the same edge.
//  req=1111, each owner releases after 2 cycles then re-requests -> grant order 0001,0010,0100,1000,0001.
//  Owner 0010 holds, req[3] rises -> grant stays 0010 until req[1] drops, then 1000 at that edge.
//  MAX_HOLD=4, req=1111 constant -> each grant lasts exactly 4 edges, rotating 0001->0010->0100->1000.
//  MAX_HOLD=4, only req[2] high for 20 cycles -> grant=0100 throughout, no preemption.
//  rst pulsed mid-grant (grant=1000) -> grant=0 without clock; after release with req=1001 -> grant=0001.
//  N=8 build, random req with 2-20 cycle holds -> one-hot held every cycle.
//  N=8 build, same stimulus, MAX_HOLD=3 -> wait never exceeds 21 edges.

Source files
------------

// File: rtl/rr_arbiter_param_pkg.sv
// Shared definitions for the round-robin arbiter: state encodings and a
// constant-evaluable ceil(log2) helper.
package rr_arbiter_param_pkg;

   localparam logic [0:0] ArbIdle  = 1'b0;
   localparam logic [0:0] ArbOwned = 1'b1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/fixed_priority_pick.sv
// Combinational fixed-priority picker: one-hot of the lowest-index set bit of req,
// all-zero when req is empty.
module fixed_priority_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] pick
);

   // Two's-complement isolates the lowest set bit.
   assign pick = req & (~req + N'(1));

endmodule

// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with registered one-hot grant, grant-hold semantics
// and an optional per-owner hold limit that preempts when others are waiting.
module rr_arbiter_param
   import rr_arbiter_param_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_HOLD = 0,
   parameter int unsigned IDX_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   localparam int unsigned HoldW = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
   // Saturation value of the hold counter; 0 disables counting when MAX_HOLD is 0.
   localparam logic [HoldW-1:0] HoldLast = (MAX_HOLD > 0) ? HoldW'(MAX_HOLD - 1) : '0;

   logic [0:0]       state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [HoldW-1:0] hold_q, hold_d;

   logic [N-1:0]     cand, mask, pick_hi, pick_lo, pick;
   logic [IDX_W-1:0] pick_idx;
   logic             owner_req, others_req, at_limit, issue;

   assign owner_req  = |(req & grant_q);
   assign others_req = |(req & ~grant_q);
   assign at_limit   = (MAX_HOLD > 0) && (hold_q == HoldLast);

   // Decide whether this edge issues a new grant and which requests compete.
   always_comb begin
      issue = 1'b0;
      cand  = req;
      if (state_q == ArbIdle) begin
         issue = |req;
      end else if (!owner_req) begin
         issue = 1'b1;
      end else if (at_limit && others_req) begin
         issue = 1'b1;
         cand  = req & ~grant_q;
      end
   end

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr_q));
      end
   end

   fixed_priority_pick #(
      .N (N)
   ) u_pick_masked (
      .req  (cand & mask),
      .pick (pick_hi)
   );

   fixed_priority_pick #(
      .N (N)
   ) u_pick_all (
      .req  (cand),
      .pick (pick_lo)
   );

   assign pick = (|pick_hi) ? pick_hi : pick_lo;

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (pick[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      if (issue) begin
         grant_d = pick;
         idx_d   = pick_idx;
         hold_d  = '0;
         if (|pick) begin
            state_d = ArbOwned;
            ptr_d   = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + IDX_W'(1);
         end else begin
            state_d = ArbIdle;
         end
      end else if ((state_q == ArbOwned) && (hold_q != HoldLast)) begin
         hold_d = hold_q + HoldW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ArbIdle;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = (state_q == ArbOwned);

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench for rr_arbiter_param: N=4 unlimited hold, N=4 with hold limit 4,
// and N=8 with hold limit 3 under random request traffic.
module tb_rr_arbiter_param;

   logic       clk;
   logic       rst;

   logic [3:0] req4, grant4;
   logic [1:0] idx4;
   logic       val4;

   logic [3:0] reqh, granth;
   logic [1:0] idxh;
   logic       valh;

   logic [7:0] req8, grant8;
   logic [2:0] idx8;
   logic       val8;

   int n_tests;
   int n_fail;

   rr_arbiter_param #(
      .N        (4),
      .MAX_HOLD (0),
      .IDX_W    (2)
   ) u_arb4 (
      .clk         (clk),
      .rst         (rst),
      .req         (req4),
      .grant       (grant4),
      .grant_idx   (idx4),
      .grant_valid (val4)
   );

   rr_arbiter_param #(
      .N        (4),
      .MAX_HOLD (4),
      .IDX_W    (2)
   ) u_arb4_hold (
      .clk         (clk),
      .rst         (rst),
      .req         (reqh),
      .grant       (granth),
      .grant_idx   (idxh),
      .grant_valid (valh)
   );

   rr_arbiter_param #(
      .N        (8),
      .MAX_HOLD (3),
      .IDX_W    (3)
   ) u_arb8 (
      .clk         (clk),
      .rst         (rst),
      .req         (req8),
      .grant       (grant8),
      .grant_idx   (idx8),
      .grant_valid (val8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at a falling edge with reset released.
   task automatic do_reset;
      req4 = '0;
      reqh = '0;
      req8 = '0;
      rst  = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
   endtask

   logic [3:0] exp_rot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   int         own    [8];
   int         len    [8];
   int         wait_c [8];
   int         max_wait;
   int         viol_onehot;
   int         viol_target;
   logic [7:0] prev_req;
   logic [7:0] prev_grant;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst  = 1'b1;
      req4 = '0;
      reqh = '0;
      req8 = '0;
      #2;
      check("rst_grant", grant4, 0);
      check("rst_idx",   idx4,   0);
      check("rst_valid", val4,   0);
      @(negedge clk);
      rst = 1'b0;

      // Basic grant then zero-bubble handoff on release.
      req4 = 4'b0101;
      tick;
      check("first_grant", grant4, 4'b0001);
      check("first_idx",   idx4,   0);
      check("first_valid", val4,   1);
      req4 = 4'b0100;
      tick;
      check("handoff_grant", grant4, 4'b0100);
      check("handoff_idx",   idx4,   2);
      req4 = 4'b0000;
      tick;
      check("idle_grant", grant4, 0);
      check("idle_valid", val4,   0);

      // Rotation with each owner releasing after two cycles.
      do_reset;
      req4 = 4'b1111;
      tick;
      for (int k = 0; k < 5; k++) begin
         check("rot_grant", grant4, exp_rot[k]);
         check("rot_idx",   idx4,   exp_idx[k]);
         tick;
         check("rot_hold",  grant4, exp_rot[k]);
         req4 = 4'b1111 & ~exp_rot[k];
         tick;
         req4 = 4'b1111;
      end

      // Owner keeps grant while another waits, hands off only on release.
      do_reset;
      req4 = 4'b0010;
      tick;
      check("own_grant", grant4, 4'b0010);
      req4 = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         tick;
         check("own_keep", grant4, 4'b0010);
      end
      req4 = 4'b1000;
      tick;
      check("own_release", grant4, 4'b1000);
      check("own_rel_idx", idx4,   3);

      // Hold limit 4 with everyone requesting: four edges per owner.
      do_reset;
      reqh = 4'b1111;
      for (int c = 0; c < 17; c++) begin
         tick;
         check("cap_rotate", granth, 4'b0001 << ((c / 4) % 4));
      end

      // Hold limit 4 with a lone requester: never preempted.
      do_reset;
      reqh = 4'b0100;
      for (int c = 0; c < 20; c++) begin
         tick;
         check("cap_alone", granth, 4'b0100);
      end
      reqh = '0;

      // Asynchronous reset in the middle of a grant.
      do_reset;
      req4 = 4'b1000;
      tick;
      check("pre_rst_grant", grant4, 4'b1000);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_grant", grant4, 0);
      check("async_rst_idx",   idx4,   0);
      check("async_rst_valid", val4,   0);
      @(negedge clk);
      rst  = 1'b0;
      req4 = 4'b1001;
      tick;
      check("post_rst_grant", grant4, 4'b0001);
      req4 = '0;

      // N=8, hold limit 3, random traffic with 2-20 cycle transactions.
      do_reset;
      max_wait    = 0;
      viol_onehot = 0;
      viol_target = 0;
      for (int i = 0; i < 8; i++) begin
         own[i]    = 0;
         len[i]    = 0;
         wait_c[i] = 0;
      end
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (req8[i]) begin
               if (grant8[i]) own[i]++;
               if (own[i] >= len[i]) req8[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               req8[i] = 1'b1;
               len[i]  = int'($urandom_range(2, 20));
               own[i]  = 0;
            end
         end
         prev_req   = req8;
         prev_grant = grant8;
         tick;
         if (!$onehot0(grant8)) viol_onehot++;
         if (val8 !== (|grant8)) viol_onehot++;
         if ((grant8 & ~prev_req) != 8'h00) viol_target++;
         if ((grant8 != prev_grant) && (grant8 != 8'h00) && ((grant8 & prev_req) == 8'h00))
            viol_target++;
         for (int i = 0; i < 8; i++) begin
            if (prev_req[i] && !grant8[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > max_wait) max_wait = wait_c[i];
         end
      end
      req8 = '0;
      check("n8_onehot_viol", viol_onehot, 0);
      check("n8_target_viol", viol_target, 0);
      check("n8_wait_le_21",  32'(max_wait <= 21), 1);
      tick;
      check("n8_drain_grant", grant8, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
